// File: rtl/sensor_hub_pkg.sv
// Shared encodings for the sensor hub: FSM states, command and status codes,
// and the DHT11-style frame checksum helper.
package sensor_hub_pkg;

  localparam int FRAME_W = 40;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ARM       = 3'd1;
  localparam state_t S_WAIT_HOLD = 3'd2;
  localparam state_t S_WAIT_DONE = 3'd3;
  localparam state_t S_EVAL      = 3'd4;
  localparam state_t S_FINISH    = 3'd5;

  typedef enum logic [3:0] {
    CMD_STATUS     = 4'd0,
    CMD_HUM_INT    = 4'd1,
    CMD_HUM_FLOAT  = 4'd2,
    CMD_TEMP_INT   = 4'd3,
    CMD_TEMP_FLOAT = 4'd4
  } cmd_e;

  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_SENSOR_ERR = 8'h80;
  localparam logic [7:0] ST_TIMEOUT    = 8'h81;
  localparam logic [7:0] ST_CHECKSUM   = 8'h82;
  localparam logic [7:0] ST_BAD_ADDR   = 8'h83;
  localparam logic [7:0] ST_BAD_CMD    = 8'h84;

  // Sum of the four payload bytes, wrapping at 8 bits.
  function automatic logic [7:0] frame_sum(input logic [FRAME_W-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/sensor_frame_eval.sv
// Combinational verdict on one captured sensor frame: driver error, checksum,
// then field selection for the requested command.
module sensor_frame_eval
  import sensor_hub_pkg::*;
(
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               error_i,
  input  logic [3:0]         cmd_i,
  output logic [7:0]         status_o,
  output logic [7:0]         data_o
);

  logic [7:0] field;

  always_comb begin
    field = 8'h00;
    case (cmd_i)
      CMD_HUM_INT:    field = frame_i[39:32];
      CMD_HUM_FLOAT:  field = frame_i[31:24];
      CMD_TEMP_INT:   field = frame_i[23:16];
      CMD_TEMP_FLOAT: field = frame_i[15:8];
      default:        field = 8'h00;
    endcase
  end

  always_comb begin
    status_o = ST_OK;
    data_o   = 8'h00;
    if (error_i) begin
      status_o = ST_SENSOR_ERR;
    end else if (frame_sum(frame_i) != frame_i[7:0]) begin
      status_o = ST_CHECKSUM;
    end else begin
      data_o = field;
    end
  end

endmodule

// File: rtl/sensor_hub.sv
// Request/response front end that sequences one of N DHT11-class drivers per
// request, applies a timeout and returns one field byte plus a status byte.
module sensor_hub
  import sensor_hub_pkg::*;
#(
  parameter int N_SENSORS      = 8,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            request_addr,
  input  logic [3:0]                   request_cmd,
  output logic                         busy,
  output logic                         finished,
  output logic [7:0]                   requested_data,
  output logic [7:0]                   status,
  output logic [N_SENSORS-1:0]         sensor_enable,
  output logic [N_SENSORS-1:0]         sensor_reset,
  input  logic [N_SENSORS-1:0]         sensor_hold,
  input  logic [N_SENSORS-1:0]         sensor_error,
  input  logic [FRAME_W*N_SENSORS-1:0] sensor_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]         data_q, data_d;
  logic [7:0]         status_q, status_d;

  logic [N_SENSORS-1:0] chan_sel;
  logic                 sel_hold, sel_err;
  logic [FRAME_W-1:0]   sel_frame;
  logic [7:0]           eval_status, eval_data;
  logic                 drive_active;

  // Mux the latched channel out of the driver buses; out-of-range addresses select nothing.
  always_comb begin
    chan_sel  = '0;
    sel_hold  = 1'b0;
    sel_err   = 1'b0;
    sel_frame = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        chan_sel[i] = 1'b1;
        sel_hold    = sensor_hold[i];
        sel_err     = sensor_error[i];
        sel_frame   = sensor_data[FRAME_W*i +: FRAME_W];
      end
    end
  end

  sensor_frame_eval u_eval (
    .frame_i  (sel_frame),
    .error_i  (sel_err),
    .cmd_i    (cmd_q),
    .status_o (eval_status),
    .data_o   (eval_data)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = request_addr;
          cmd_d  = request_cmd;
          if (int'(request_addr) >= N_SENSORS) begin
            state_d  = S_FINISH;
            status_d = ST_BAD_ADDR;
            data_d   = 8'h00;
          end else if (request_cmd > CMD_TEMP_FLOAT) begin
            state_d  = S_FINISH;
            status_d = ST_BAD_CMD;
            data_d   = 8'h00;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_WAIT_HOLD;
      end
      S_WAIT_HOLD, S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        // Timeout outranks a hold edge seen in the same cycle.
        if (cnt_inc >= CNT_LIMIT) begin
          state_d  = S_FINISH;
          status_d = ST_TIMEOUT;
          data_d   = 8'h00;
        end else if (state_q == S_WAIT_HOLD && sel_hold) begin
          state_d = S_WAIT_DONE;
        end else if (state_q == S_WAIT_DONE && !sel_hold) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        status_d = eval_status;
        data_d   = eval_data;
        state_d  = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign drive_active = (state_q == S_ARM) || (state_q == S_WAIT_HOLD) ||
                        (state_q == S_WAIT_DONE) || (state_q == S_EVAL);

  assign busy           = (state_q != S_IDLE);
  assign finished       = (state_q == S_FINISH);
  assign requested_data = data_q;
  assign status         = status_q;
  assign sensor_enable  = drive_active ? chan_sel : '0;
  assign sensor_reset   = (state_q == S_ARM) ? chan_sel : '0;

endmodule

// File: doc/sensor_hub.md
Name: sensor_hub

Overview:
- Parametrised successor to the single-DHT11 sensor decoder facade: one request/response front end arbitrating up to 32 DHT11-class sensor driver instances.
- Selects a channel per request, sequences its driver (reset pulse, enable, wait for frame), applies a timeout, verifies the checksum and returns one requested field byte plus a status byte.
- Sits between the UART command layer and the per-sensor driver instances; the drivers own the bidirectional transmission lines, so this block has no inout ports.

Parameters:
- N_SENSORS, 8, number of driver channels, 1..32.
- ADDR_W, 5, width of the request address; 2^ADDR_W >= N_SENSORS.
- TIMEOUT_CYCLES, 50_000_000, cycles allowed from ARM until the driver's hold falls (1 s at 50 MHz).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- request_addr  in  ADDR_W  sensor channel index.
- request_cmd  in  4  field selector: 0 status, 1 hum_int, 2 hum_float, 3 temp_int, 4 temp_float.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle pulse; response outputs valid from this cycle.
- requested_data  out  8  selected field byte; 0 for the status command and on any error.
- status  out  8  0x00 OK, 0x80 sensor error, 0x81 timeout, 0x82 checksum, 0x83 bad address, 0x84 bad command.
- sensor_enable  out  N_SENSORS  per-channel driver enable.
- sensor_reset  out  N_SENSORS  per-channel driver reset.
- sensor_hold  in  N_SENSORS  per-channel driver busy/hold.
- sensor_error  in  N_SENSORS  per-channel driver error.
- sensor_data  in  40*N_SENSORS  channel i at [40*i +: 40] = {hum_int, hum_float, temp_int, temp_float, checksum}, MSB first.

Behaviour:
- Reset: state IDLE; busy, finished, requested_data, status, sensor_enable, sensor_reset, timeout counter all 0. Reset wins over every other event in the same cycle. Reset mid-transaction aborts with no finished pulse and drops all enables in the next cycle.
- IDLE: on start, latch addr and cmd.
  - addr >= N_SENSORS: go to FINISH, status 0x83.
  - cmd > 4: go to FINISH, status 0x84.
  - Address is checked before command.
  - Otherwise go to ARM. With start at cycle t, the error finished pulse lands at t+1.
- ARM (1 cycle): sensor_enable[addr]=1, sensor_reset[addr]=1; clear the timeout counter. Next state WAIT_HOLD.
- WAIT_HOLD: enable held, reset 0. sensor_hold[addr]=1 -> WAIT_DONE.
- WAIT_DONE: sensor_hold[addr]=0 -> EVAL.
- Timeout: counter increments every cycle in WAIT_HOLD and WAIT_DONE. On reaching TIMEOUT_CYCLES-1 -> FINISH with status 0x81. Timeout takes priority over a hold transition in the same cycle.
- EVAL (1 cycle): capture the 40-bit frame and sensor_error[addr].
  - Error set: status 0x80.
  - Else sum of bytes 4..1 mod 256 != checksum: status 0x82.
  - Else status 0x00 and requested_data = selected field.
- FINISH (1 cycle): finished=1, sensor_enable all 0, then IDLE.
- requested_data and status hold their values until the next FINISH.
- Only the latched channel's enable/reset may ever be high; all other channels stay 0.
- start while busy is ignored (not queued).
- Hold or error toggles on non-selected channels are ignored.
- Success latency: start at t, ARM at t+1, hold fall observed at t+k, EVAL at t+k+1, finished at t+k+2.

Decomposition:
- Package sensor_hub_pkg:
  - state encoding IDLE/ARM/WAIT_HOLD/WAIT_DONE/EVAL/FINISH;
  - command codes CMD_STATUS..CMD_TEMP_FLOAT;
  - status codes ST_OK, ST_SENSOR_ERR, ST_TIMEOUT, ST_CHECKSUM, ST_BAD_ADDR, ST_BAD_CMD;
  - FRAME_W=40.
- Sub-module sensor_frame_eval: purely combinational. Inputs 40-bit frame, error bit, cmd. Outputs status byte and data byte. Keeps the checksum and field-select logic unit-testable.

Test Plan:
- N_SENSORS=8. start with addr=3, cmd=3; driver 3 raises hold 5 cycles after ARM and drops it 20 cycles later, frame {0x2D,0x00,0x17,0x04,0x48} -> finished once, requested_data=0x17, status=0x00, only sensor_enable[3] ever high.
- Same frame with checksum byte 0x49, cmd=1 -> status=0x82, requested_data=0x00.
- TIMEOUT_CYCLES=100, driver never raises hold -> finished exactly 100 cycles after ARM, status=0x81, all enables 0 afterwards.
- addr=9 (N_SENSORS=8) -> finished at t+1, status=0x83, no sensor_enable activity. Separately, addr=0 with cmd=7 -> status=0x84.
- Driver 2 reports error=1 at hold fall, cmd=2 -> status=0x80, requested_data=0x00. A second start pulsed during WAIT_DONE produces no extra transaction.
- Assert reset in WAIT_DONE -> next cycle busy=0, enables=0, outputs 0, no finished pulse. A fresh start then completes normally.
